// File: rtl/dram_refresh_sched_if.sv
// Signal bundle between the DRAM command sequencer (master) and the refresh scheduler (slave).
// fsm_state is a debug view of the scheduler state: 0 DISABLED, 1 READY, 2 PRECHARGING_ALL, 3 REFRESHING.
interface dram_refresh_sched_if;
    logic       init_done;
    logic       bank_idle;
    logic       ref_ack;
    logic       pre_ack;
    logic       ref_req;
    logic       ref_urgent;
    logic       pre_all_req;
    logic       ref_busy;
    logic [3:0] pending_cnt;
    logic       ref_err;
    logic [1:0] fsm_state;

    // Handshake: ref_ack/pre_ack are single-cycle pulses from the sequencer. An ack takes effect on the
    // rising edge where its request is high (ref_ack also needs bank_idle); an ack without one is dropped.
    modport master (
        output init_done, bank_idle, ref_ack, pre_ack,
        input  ref_req, ref_urgent, pre_all_req, ref_busy, pending_cnt, ref_err, fsm_state
    );

    modport slave (
        input  init_done, bank_idle, ref_ack, pre_ack,
        output ref_req, ref_urgent, pre_all_req, ref_busy, pending_cnt, ref_err, fsm_state
    );
endinterface

// File: rtl/dram_refresh_sched.sv
// DRAM refresh scheduler: tracks owed refreshes per tREFI, escalates to urgent/precharge-all,
// and blocks commands during tRFC and tRP windows.
module dram_refresh_sched #(
    parameter int TREFI        = 250,
    parameter int TRFC         = 172,
    parameter int TRP          = 10,
    parameter int MAX_POSTPONE = 8
) (
    input logic                  clk,
    input logic                  rst,
    dram_refresh_sched_if.slave  bus
);
    localparam int IW = $clog2(TREFI + 1);
    localparam int WW = $clog2(((TRFC > TRP) ? TRFC : TRP) + 1);
    localparam logic [IW-1:0] IVL_LAST  = IW'(TREFI - 1);
    localparam logic [WW-1:0] RFC_LOAD  = WW'(TRFC - 1);
    localparam logic [WW-1:0] RP_LOAD   = WW'(TRP - 1);
    localparam logic [3:0]    URG_LVL   = 4'(MAX_POSTPONE);
    localparam logic [3:0]    PEND_MAX  = 4'(MAX_POSTPONE + 1);

    typedef enum logic [1:0] {
        DISABLED        = 2'd0,
        READY           = 2'd1,
        PRECHARGING_ALL = 2'd2,
        REFRESHING      = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] ivl_cnt, ivl_next;
    logic [WW-1:0] wait_cnt, wait_next;
    logic [3:0]    pend, pend_next;
    logic          err, err_next;
    logic          tick, ref_ok, pre_ok;

    assign tick            = (state != DISABLED) && (ivl_cnt == IVL_LAST);
    assign bus.ref_req     = (state == READY) && (pend != 4'd0);
    assign bus.ref_urgent  = (pend >= URG_LVL);
    assign bus.pre_all_req = (state == READY) && bus.ref_urgent && !bus.bank_idle;
    assign bus.ref_busy    = (state == REFRESHING) || (state == PRECHARGING_ALL);
    assign bus.pending_cnt = pend;
    assign bus.ref_err     = err;
    assign bus.fsm_state   = state;

    // Refresh wins a same-cycle collision; in practice the two are exclusive through bank_idle.
    assign ref_ok = bus.ref_req && bus.bank_idle && bus.ref_ack;
    assign pre_ok = bus.pre_all_req && bus.pre_ack && !ref_ok;

    always_comb begin
        state_next = state;
        ivl_next   = ivl_cnt;
        wait_next  = wait_cnt;
        pend_next  = pend;
        err_next   = err;
        if (!bus.init_done) begin
            state_next = DISABLED;
            ivl_next   = '0;
            wait_next  = '0;
            pend_next  = '0;
            err_next   = 1'b0;
        end else if (state == DISABLED) begin
            state_next = READY;
        end else begin
            ivl_next = tick ? '0 : ivl_cnt + 1'b1;
            if (tick && (pend == PEND_MAX))
                err_next = 1'b1;
            if (tick && !ref_ok && (pend != PEND_MAX))
                pend_next = pend + 4'd1;
            else if (ref_ok && !tick)
                pend_next = pend - 4'd1;
            case (state)
                READY: begin
                    if (ref_ok) begin
                        state_next = REFRESHING;
                        wait_next  = RFC_LOAD;
                    end else if (pre_ok) begin
                        state_next = PRECHARGING_ALL;
                        wait_next  = RP_LOAD;
                    end
                end
                REFRESHING, PRECHARGING_ALL: begin
                    if (wait_cnt == '0)
                        state_next = READY;
                    else
                        wait_next = wait_cnt - 1'b1;
                end
                default: state_next = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DISABLED;
            ivl_cnt  <= '0;
            wait_cnt <= '0;
            pend     <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            ivl_cnt  <= ivl_next;
            wait_cnt <= wait_next;
            pend     <= pend_next;
            err      <= err_next;
        end
    end
endmodule

// File: tb/tb_dram_refresh_sched.sv
// Self-checking bench for dram_refresh_sched: directed scenarios plus a randomized run,
// all compared against a cycle-count reference model of the refresh rules.
module tb_dram_refresh_sched;
    localparam int TREFI = 250;
    localparam int TRFC  = 172;
    localparam int TRP   = 10;
    localparam int MAXP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   t = 0;

    dram_refresh_sched_if bus ();

    dram_refresh_sched #(.TREFI(TREFI), .TRFC(TRFC), .TRP(TRP), .MAX_POSTPONE(MAXP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: enabled flag, cycles since enable, owed refreshes, sticky error, busy cycles left.
    bit m_en = 0;
    int m_age = 0;
    int m_owed = 0;
    bit m_err = 0;
    int m_busy = 0;
    bit m_busy_ref = 0;
    logic [10:0] exp_q[$];

    task automatic model_step();
        bit tick, acc, pre;
        if (rst || !bus.init_done) begin
            m_en = 0; m_age = 0; m_owed = 0; m_err = 0; m_busy = 0;
        end else if (!m_en) begin
            m_en = 1; m_age = 0;
        end else begin
            tick = ((m_age % TREFI) == TREFI - 1);
            acc  = (m_busy == 0) && (m_owed != 0) && bus.bank_idle && bus.ref_ack;
            pre  = !acc && (m_busy == 0) && (m_owed >= MAXP) && !bus.bank_idle && bus.pre_ack;
            if (tick && m_owed == MAXP + 1) m_err = 1;
            m_owed = m_owed + (tick ? 1 : 0) - (acc ? 1 : 0);
            if (m_owed > MAXP + 1) m_owed = MAXP + 1;
            if (m_busy > 0) m_busy--;
            if (acc) begin m_busy = TRFC; m_busy_ref = 1; end
            if (pre) begin m_busy = TRP;  m_busy_ref = 0; end
            m_age++;
        end
    endtask

    function automatic logic [10:0] exp_vec();
        logic [1:0] st;
        logic rq, ug, pr, bz;
        st = !m_en ? 2'd0 : (m_busy > 0) ? (m_busy_ref ? 2'd3 : 2'd2) : 2'd1;
        rq = m_en && (m_busy == 0) && (m_owed != 0);
        ug = (m_owed >= MAXP);
        pr = m_en && (m_busy == 0) && ug && !bus.bank_idle;
        bz = (m_busy > 0);
        return {st, rq, ug, pr, bz, m_err, 4'(m_owed)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.fsm_state, bus.ref_req, bus.ref_urgent, bus.pre_all_req, bus.ref_busy,
                bus.ref_err, bus.pending_cnt};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic enable();
        bus.ref_ack = 0; bus.pre_ack = 0;
        bus.init_done = 0;
        cyc();
        bus.init_done = 1;
        cyc();
        t = 0;
    endtask

    task automatic run_to(input int n);
        while (t < n) cyc();
    endtask

    task automatic test_reset();
        rst = 1; bus.init_done = 1; bus.bank_idle = 1; bus.ref_ack = 1; bus.pre_ack = 1;
        repeat (3) cyc();
        checks++;
        if (dut_vec() !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", dut_vec(), 11'd0);
        end
        rst = 0; bus.ref_ack = 0; bus.pre_ack = 0;
    endtask

    task automatic test_tick_ack();
        int busy_cycles;
        bus.bank_idle = 1;
        enable();
        while (t < 250) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL tick_walk t=%0d: got %b want %b", t, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.ref_req !== 1'b1 || bus.pending_cnt !== 4'd1) begin
            errors++;
            $display("FAIL first_tick: req=%b pend=%0d want req=1 pend=1", bus.ref_req, bus.pending_cnt);
        end
        run_to(260);
        bus.ref_ack = 1;
        cyc();
        bus.ref_ack = 0;
        busy_cycles = 0;
        while (t < 440) begin
            if (bus.ref_busy === 1'b1) busy_cycles++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL trfc_walk t=%0d: got %b want %b", t, dut_vec(), exp_vec());
            end
            cyc();
        end
        checks++;
        if (busy_cycles != TRFC || bus.pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL trfc_len: busy=%0d pend=%0d want busy=%0d pend=0", busy_cycles, bus.pending_cnt, TRFC);
        end
    endtask

    task automatic test_urgency();
        bus.bank_idle = 1;
        enable();
        while (t < 2501) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL urgency_walk t=%0d: got %b want %b", t, dut_vec(), exp_vec());
            end
            if (t == 2000 || t == 2250) begin
                checks++;
                if (bus.ref_urgent !== 1'b1 || bus.pending_cnt !== 4'((t == 2000) ? 8 : 9)) begin
                    errors++;
                    $display("FAIL urgent_at t=%0d: urg=%b pend=%0d", t, bus.ref_urgent, bus.pending_cnt);
                end
            end
        end
        checks++;
        if (bus.ref_err !== 1'b1 || bus.pending_cnt !== 4'd9) begin
            errors++;
            $display("FAIL overflow_err: err=%b pend=%0d want err=1 pend=9", bus.ref_err, bus.pending_cnt);
        end
    endtask

    task automatic test_precharge();
        bus.bank_idle = 1;
        enable();
        run_to(2000);
        bus.bank_idle = 0;
        #1;
        checks++;
        if (bus.pre_all_req !== 1'b1 || bus.pending_cnt !== 4'd8) begin
            errors++;
            $display("FAIL pre_all_req: got %b pend=%0d want 1 pend=8", bus.pre_all_req, bus.pending_cnt);
        end
        repeat ($urandom_range(1, 5)) cyc();
        bus.pre_ack = 1;
        cyc();
        bus.pre_ack = 0;
        repeat (TRP) begin
            checks++;
            if (bus.ref_busy !== 1'b1 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL trp_window t=%0d: got %b want %b", t, dut_vec(), exp_vec());
            end
            cyc();
        end
        bus.bank_idle = 1;
        #1;
        checks++;
        if (bus.ref_busy !== 1'b0 || bus.ref_req !== 1'b1) begin
            errors++;
            $display("FAIL trp_end: busy=%b req=%b want busy=0 req=1", bus.ref_busy, bus.ref_req);
        end
        bus.ref_ack = 1;
        cyc();
        bus.ref_ack = 0;
        checks++;
        if (bus.ref_busy !== 1'b1 || bus.pending_cnt !== 4'd7 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_pre_refresh: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        bus.bank_idle = 1;
        enable();
        run_to(499);
        bus.ref_ack = 1;
        cyc();
        bus.ref_ack = 0;
        checks++;
        if (bus.pending_cnt !== 4'd1 || bus.ref_busy !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL tick_plus_ack: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_gating();
        bus.bank_idle = 1;
        enable();
        run_to(255);
        bus.bank_idle = 0;
        bus.ref_ack = 1;
        cyc();
        bus.ref_ack = 0;
        checks++;
        if (bus.fsm_state !== 2'd1 || bus.pending_cnt !== 4'd1 || bus.ref_busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_not_idle: state=%0d pend=%0d busy=%b", bus.fsm_state, bus.pending_cnt, bus.ref_busy);
        end
        bus.pre_ack = 1;
        cyc();
        bus.pre_ack = 0;
        checks++;
        if (bus.ref_busy !== 1'b0 || bus.fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL stray_pre_ack: state=%0d busy=%b want state=1 busy=0", bus.fsm_state, bus.ref_busy);
        end
        bus.bank_idle = 1;
        bus.ref_ack = 1;
        cyc();
        bus.ref_ack = 0;
        repeat (20) cyc();
        bus.ref_ack = 1;
        cyc();
        bus.ref_ack = 0;
        checks++;
        if (bus.fsm_state !== 2'd3 || bus.pending_cnt !== 4'd0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ack_while_busy: got %b want %b", dut_vec(), exp_vec());
        end
        run_to(t + TRFC);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL busy_not_extended: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_abort();
        for (int pass = 0; pass < 2; pass++) begin
            bus.bank_idle = 1;
            enable();
            run_to(260);
            bus.ref_ack = 1;
            cyc();
            bus.ref_ack = 0;
            run_to(300);
            if (pass == 0) bus.init_done = 0;
            else rst = 1;
            cyc();
            checks++;
            if (bus.fsm_state !== 2'd0 || bus.pending_cnt !== 4'd0 || bus.ref_busy !== 1'b0
                || dut_vec() !== 11'd0) begin
                errors++;
                $display("FAIL abort_%s: got %b want all zero", (pass == 0) ? "init" : "rst", dut_vec());
            end
            rst = 0;
            bus.init_done = 1;
        end
    endtask

    task automatic test_random();
        logic [10:0] want;
        enable();
        for (int i = 0; i < 4000; i++) begin
            bus.bank_idle = ($urandom_range(0, 3) != 0);
            bus.ref_ack   = ($urandom_range(0, 99) < 2);
            bus.pre_ack   = ($urandom_range(0, 99) < 5);
            bus.init_done = ($urandom_range(0, 1499) != 0);
            rst           = ($urandom_range(0, 2999) == 0);
            cyc();
            exp_q.push_back(exp_vec());
            want = exp_q.pop_front();
            checks++;
            if (dut_vec() !== want) begin
                errors++;
                $display("FAIL random i=%0d: got %b want %b", i, dut_vec(), want);
            end
        end
        rst = 0;
        bus.ref_ack = 0;
        bus.pre_ack = 0;
    endtask

    initial begin
        bus.init_done = 0; bus.bank_idle = 1; bus.ref_ack = 0; bus.pre_ack = 0;
        test_reset();
        test_tick_ack();
        test_urgency();
        test_precharge();
        test_simultaneous();
        test_gating();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dram_refresh_sched.md
DRAM_REFRESH_SCHED -- requirements
Module: dram_refresh_sched

Interface
REQ-001 The block SHALL expose parameter TREFI, default 250, the refresh interval in CLK cycles.
REQ-002 The block SHALL expose parameter TRFC, default 172, the refresh-to-next-command time in cycles.
REQ-003 The block SHALL expose parameter TRP, default 10, the precharge-all recovery time in cycles.
REQ-004 The block SHALL expose parameter MAX_POSTPONE, default 8, the number of refreshes that may be postponed before urgency.
REQ-005 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 init_done  input  1  DRAM init sequence is complete; the scheduler is enabled while high.
REQ-008 bank_idle  input  1  all banks are precharged.
REQ-009 ref_ack  input  1  the command sequencer issued REFRESH_CMD this cycle.
REQ-010 pre_ack  input  1  the command sequencer issued PRECHARGE_CMD (all banks) this cycle.
REQ-011 ref_req  output  1  a refresh is owed.
REQ-012 ref_urgent  output  1  the postponement limit has been reached; the sequencer must stop issuing ACT/RD/WR.
REQ-013 pre_all_req  output  1  request for a precharge-all ahead of an urgent refresh.
REQ-014 ref_busy  output  1  a tRFC or tRP window is in progress; no command may be issued.
REQ-015 pending_cnt  output  4  the number of owed refreshes.
REQ-016 ref_err  output  1  sticky flag indicating the refresh limit was exceeded.

Function
REQ-017 The block SHALL implement four states: DISABLED, READY, PRECHARGING_ALL and REFRESHING.
REQ-018 In DISABLED, the interval counter and pending_cnt SHALL be held at 0 and all outputs SHALL be 0; the block SHALL move to READY on the first cycle in which init_done is high.
REQ-019 The interval counter SHALL count 0..TREFI-1 in every state other than DISABLED, and on wrap from TREFI-1 to 0 SHALL raise a tick for one cycle.
REQ-020 The first tick SHALL occur TREFI cycles after entry to READY.
REQ-021 On a tick, pending_cnt SHALL increment by 1, saturating at MAX_POSTPONE+1.
REQ-022 A tick that occurs while pending_cnt is already MAX_POSTPONE+1 SHALL set ref_err, which stays set until RST or init_done low.
REQ-023 ref_req SHALL be combinational: ref_req = (state==READY) && (pending_cnt!=0).
REQ-024 ref_urgent SHALL be combinational: ref_urgent = (pending_cnt >= MAX_POSTPONE), and it is independent of state.
REQ-025 In READY, ref_ack SHALL be accepted only when ref_req=1 and bank_idle=1.
REQ-026 On an accepted ref_ack, the block SHALL decrement pending_cnt, enter REFRESHING, and load the wait counter with TRFC-1.
REQ-027 A ref_ack that is not accepted SHALL be ignored with no state change.
REQ-028 A tick coinciding with an accepted ref_ack SHALL leave pending_cnt unchanged (net 0).
REQ-029 In REFRESHING, ref_busy SHALL be 1 and the wait counter SHALL decrement each cycle; the block SHALL return to READY in the cycle after the counter reaches 0.
REQ-030 ref_busy SHALL therefore be high for exactly TRFC cycles.
REQ-031 In READY with ref_urgent=1 and bank_idle=0, pre_all_req SHALL be 1 (combinational) and SHALL remain high until pre_ack.
REQ-032 On pre_ack while pre_all_req=1, the block SHALL enter PRECHARGING_ALL with ref_busy=1 for exactly TRP cycles, then return to READY.
REQ-033 A pre_ack received while pre_all_req=0 SHALL be ignored.
REQ-034 In READY, if ref_ack and pre_ack arrive in the same cycle, ref_ack SHALL take priority when it is accepted; otherwise pre_ack SHALL be handled per REQ-032.
REQ-035 If init_done falls in any state, the block SHALL enter DISABLED on the next edge, clearing all counters, pending_cnt and ref_err.
REQ-036 In-flight tRFC/tRP waits SHALL be abandoned when init_done falls.

Reset
REQ-037 While RST=1, the state SHALL be DISABLED, all counters SHALL be 0, ref_err SHALL be 0, and every output SHALL be 0.
REQ-038 RST SHALL take priority over every other input.
REQ-039 Asserting RST mid-REFRESHING or mid-PRECHARGING_ALL SHALL abort the wait immediately.

Verification
REQ-040 Tick/ack scenario: init_done=1 at cycle 0, bank_idle=1, no ack -> ref_req rises at cycle 250 with pending_cnt=1; ref_ack at cycle 260 -> ref_busy high for cycles 261..432 and pending_cnt=0.
REQ-041 Urgency/error scenario: no ack for 9×250 cycles -> ref_urgent rises when pending_cnt=8, pending_cnt=9 at cycle 2250, and the tick at cycle 2500 sets ref_err while pending_cnt stays 9.
REQ-042 Precharge-all scenario: pending_cnt=8 with bank_idle=0 -> pre_all_req=1; pre_ack -> ref_busy for 10 cycles, then bank_idle=1 and ref_ack -> tRFC window starts and pending_cnt=7.
REQ-043 Simultaneous scenario: an accepted ref_ack on a tick cycle -> pending_cnt unchanged.
REQ-044 Gating scenario: ref_ack with bank_idle=0, and ref_ack while REFRESHING -> both ignored, with no change to pending_cnt or state.
REQ-045 Abort scenario: init_done dropped at cycle 300 during REFRESHING -> the next cycle shows DISABLED, pending_cnt=0, ref_busy=0; RST asserted with the same stimulus -> identical outcome.
